pc_redirect_arbiter: RTL and testbench

// - Receiving end of the sub-SIC pc_redirect_* pulse interface. Collects one-cycle redirect pulses from
//   NUM_SIC execution sub-SICs (JR, branch, exception), keeps the oldest by issue_id (wrap-aware, relative
//   to the ROB/issue head), and presents one redirect to fetch over a valid/ready handshake.
// - Sits between the SIC array and the fetch PC register; sub-SICs never stall, so this block buffers and filters.

---
 rtl/pc_redirect_arbiter.sv | 138 +++++++++++++
 tb/tb_pc_redirect_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_arbiter.sv
// Collects one-cycle redirect pulses from the execution sub-SICs, keeps the oldest by
// issue_id age relative to the ROB head, and offers it to fetch over valid/ready.
module pc_redirect_arbiter #(
    parameter int NUM_SIC  = 4,
    parameter int ID_WIDTH = 6,
    parameter int PC_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SIC-1:0]           redir_valid,
    input  logic [NUM_SIC*PC_WIDTH-1:0]  redir_pc,
    input  logic [NUM_SIC*ID_WIDTH-1:0]  redir_issue_id,
    input  logic [ID_WIDTH-1:0]          head_issue_id,
    output logic                         fetch_redirect_valid,
    output logic [PC_WIDTH-1:0]          fetch_redirect_pc,
    output logic [ID_WIDTH-1:0]          fetch_redirect_id,
    input  logic                         fetch_redirect_ready,
    output logic [31:0]                  redirect_count,
    output logic [15:0]                  drop_count
);

    localparam int CW = $clog2(NUM_SIC + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [PC_WIDTH-1:0] held_pc, held_pc_nxt;
    logic [ID_WIDTH-1:0] held_id, held_id_nxt;

    logic [ID_WIDTH-1:0] src_age [NUM_SIC];
    logic                win_valid;
    logic [ID_WIDTH-1:0] win_age;
    logic [PC_WIDTH-1:0] win_pc;
    logic [ID_WIDTH-1:0] win_id;
    logic [CW-1:0]       n_valid;

    logic [ID_WIDTH-1:0] held_age;
    logic                win_older;
    logic                accept;
    logic                extra_drop;
    logic [CW-1:0]       drops;
    logic [16:0]         drop_sum;

    // Ages are modular distances from the head, so raw id order never matters.
    always_comb begin
        for (int i = 0; i < NUM_SIC; i++) begin
            src_age[i] = redir_issue_id[i*ID_WIDTH +: ID_WIDTH] - head_issue_id;
        end
    end

    // Strict less-than keeps the lowest index on an age tie.
    always_comb begin
        win_valid = 1'b0;
        win_age   = '0;
        win_pc    = '0;
        win_id    = '0;
        n_valid   = '0;
        for (int i = 0; i < NUM_SIC; i++) begin
            if (redir_valid[i]) begin
                n_valid = n_valid + CW'(1);
                if (!win_valid || (src_age[i] < win_age)) begin
                    win_valid = 1'b1;
                    win_age   = src_age[i];
                    win_pc    = redir_pc[i*PC_WIDTH +: PC_WIDTH];
                    win_id    = redir_issue_id[i*ID_WIDTH +: ID_WIDTH];
                end
            end
        end
    end

    assign held_age  = held_id - head_issue_id;
    assign win_older = win_valid && (win_age < held_age);

    always_comb begin
        state_nxt   = state;
        held_pc_nxt = held_pc;
        held_id_nxt = held_id;
        accept      = 1'b0;
        extra_drop  = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    held_pc_nxt = win_pc;
                    held_id_nxt = win_id;
                    state_nxt   = PENDING;
                end
            end
            PENDING: begin
                if (fetch_redirect_ready) begin
                    accept = 1'b1;
                    if (win_older) begin
                        held_pc_nxt = win_pc;
                        held_id_nxt = win_id;
                    end else begin
                        extra_drop = win_valid;
                        state_nxt  = IDLE;
                    end
                end else if (win_valid) begin
                    // Either the held entry is superseded or the winner loses; one drop either way.
                    extra_drop = 1'b1;
                    if (win_older) begin
                        held_pc_nxt = win_pc;
                        held_id_nxt = win_id;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign drops    = n_valid - CW'(win_valid) + CW'(extra_drop);
    assign drop_sum = {1'b0, drop_count} + 17'(drops);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            held_pc        <= '0;
            held_id        <= '0;
            redirect_count <= '0;
            drop_count     <= '0;
        end else begin
            state          <= state_nxt;
            held_pc        <= held_pc_nxt;
            held_id        <= held_id_nxt;
            redirect_count <= redirect_count + 32'(accept);
            drop_count     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign fetch_redirect_valid = (state == PENDING);
    assign fetch_redirect_pc    = held_pc;
    assign fetch_redirect_id    = held_id;

endmodule

// File: tb/tb_pc_redirect_arbiter.sv
// Directed bench for pc_redirect_arbiter: selection, age wrap, replacement, accept,
// saturation of the drop counter and asynchronous reset.
module tb_pc_redirect_arbiter;

    localparam int NS = 4;
    localparam int IW = 6;
    localparam int PW = 32;

    logic              clk;
    logic              rst_n;
    logic [NS-1:0]     redir_valid;
    logic [NS*PW-1:0]  redir_pc;
    logic [NS*IW-1:0]  redir_issue_id;
    logic [IW-1:0]     head_issue_id;
    logic              fetch_redirect_valid;
    logic [PW-1:0]     fetch_redirect_pc;
    logic [IW-1:0]     fetch_redirect_id;
    logic              fetch_redirect_ready;
    logic [31:0]       redirect_count;
    logic [15:0]       drop_count;

    int n_checks = 0;
    int n_errors = 0;

    pc_redirect_arbiter #(.NUM_SIC(NS), .ID_WIDTH(IW), .PC_WIDTH(PW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .redir_valid          (redir_valid),
        .redir_pc             (redir_pc),
        .redir_issue_id       (redir_issue_id),
        .head_issue_id        (head_issue_id),
        .fetch_redirect_valid (fetch_redirect_valid),
        .fetch_redirect_pc    (fetch_redirect_pc),
        .fetch_redirect_id    (fetch_redirect_id),
        .fetch_redirect_ready (fetch_redirect_ready),
        .redirect_count       (redirect_count),
        .drop_count           (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        redir_valid = '0;
    endtask

    task automatic set_src(input int s, input logic [IW-1:0] id, input logic [PW-1:0] pc);
        redir_valid[s]           = 1'b1;
        redir_issue_id[s*IW +: IW] = id;
        redir_pc[s*PW +: PW]       = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [PW-1:0] pc,
                              input logic [IW-1:0] id, input logic [31:0] cnt, input logic [15:0] drp);
        check({tag, ".valid"}, 32'(fetch_redirect_valid), 32'(v));
        if (v) begin
            check({tag, ".pc"}, fetch_redirect_pc, pc);
            check({tag, ".id"}, 32'(fetch_redirect_id), 32'(id));
        end
        check({tag, ".count"}, redirect_count, cnt);
        check({tag, ".drops"}, 32'(drop_count), 32'(drp));
    endtask

    initial begin
        rst_n                = 1'b0;
        redir_valid          = '0;
        redir_pc             = '0;
        redir_issue_id       = '0;
        head_issue_id        = '0;
        fetch_redirect_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", 32'(fetch_redirect_valid), 32'd0);
        check("reset.pc",    fetch_redirect_pc, 32'd0);
        check("reset.id",    32'(fetch_redirect_id), 32'd0);
        check("reset.count", redirect_count, 32'd0);
        check("reset.drops", 32'(drop_count), 32'd0);
        rst_n = 1'b1;

        // single pulse, one-cycle latency, accepted next cycle
        set_src(1, 6'd3, 32'h400);
        step();
        expect_out("single", 1'b1, 32'h400, 6'd3, 32'd0, 16'd0);
        clr();
        step();
        expect_out("single_acc", 1'b0, 32'h0, 6'd0, 32'd1, 16'd0);

        // same-cycle race
        fetch_redirect_ready = 1'b0;
        set_src(0, 6'd5, 32'h100);
        set_src(2, 6'd2, 32'h200);
        step();
        expect_out("race", 1'b1, 32'h200, 6'd2, 32'd1, 16'd1);
        clr();
        fetch_redirect_ready = 1'b1;
        step();
        expect_out("race_acc", 1'b0, 32'h0, 6'd0, 32'd2, 16'd1);

        // wrap-around ages: head 62, id 63 is age 1, id 1 is age 3
        head_issue_id        = 6'd62;
        fetch_redirect_ready = 1'b0;
        set_src(0, 6'd1,  32'h010);
        set_src(1, 6'd63, 32'h63C);
        step();
        expect_out("wrap", 1'b1, 32'h63C, 6'd63, 32'd2, 16'd2);
        clr();
        fetch_redirect_ready = 1'b1;
        step();
        expect_out("wrap_acc", 1'b0, 32'h0, 6'd0, 32'd3, 16'd2);
        head_issue_id = 6'd0;

        // replace while stalled, then a younger pulse is dropped
        fetch_redirect_ready = 1'b0;
        set_src(3, 6'd4, 32'h440);
        step();
        expect_out("hold4", 1'b1, 32'h440, 6'd4, 32'd3, 16'd2);
        clr();
        set_src(0, 6'd2, 32'h220);
        step();
        expect_out("replace2", 1'b1, 32'h220, 6'd2, 32'd3, 16'd3);
        clr();
        set_src(1, 6'd7, 32'h770);
        step();
        expect_out("drop7", 1'b1, 32'h220, 6'd2, 32'd3, 16'd4);
        clr();
        step();
        expect_out("stable", 1'b1, 32'h220, 6'd2, 32'd3, 16'd4);

        // accept plus older pulse in the same cycle
        fetch_redirect_ready = 1'b1;
        set_src(2, 6'd1, 32'h110);
        step();
        expect_out("acc_older", 1'b1, 32'h110, 6'd1, 32'd4, 16'd4);
        clr();
        step();
        expect_out("acc_older2", 1'b0, 32'h0, 6'd0, 32'd5, 16'd4);

        // accept plus younger pulse: pulse dropped, back to idle
        fetch_redirect_ready = 1'b0;
        set_src(0, 6'd10, 32'hA00);
        step();
        expect_out("hold10", 1'b1, 32'hA00, 6'd10, 32'd5, 16'd4);
        clr();
        fetch_redirect_ready = 1'b1;
        set_src(1, 6'd12, 32'hC00);
        step();
        expect_out("acc_younger", 1'b0, 32'h0, 6'd0, 32'd6, 16'd5);
        clr();

        // head moves past the held id: raw-older id 10 becomes the youngest
        fetch_redirect_ready = 1'b0;
        set_src(0, 6'd10, 32'hB00);
        step();
        expect_out("hold10b", 1'b1, 32'hB00, 6'd10, 32'd6, 16'd5);
        clr();
        head_issue_id = 6'd12;
        set_src(3, 6'd30, 32'h300);
        step();
        expect_out("head_move", 1'b1, 32'h300, 6'd30, 32'd6, 16'd6);
        clr();
        fetch_redirect_ready = 1'b1;
        step();
        expect_out("head_acc", 1'b0, 32'h0, 6'd0, 32'd7, 16'd6);
        head_issue_id = 6'd0;

        // age tie: lowest index wins
        fetch_redirect_ready = 1'b0;
        set_src(1, 6'd9, 32'h901);
        set_src(3, 6'd9, 32'h903);
        step();
        expect_out("tie", 1'b1, 32'h901, 6'd9, 32'd7, 16'd7);
        clr();
        fetch_redirect_ready = 1'b1;
        step();
        expect_out("tie_acc", 1'b0, 32'h0, 6'd0, 32'd8, 16'd7);

        // saturation: hold id 0, then four younger pulses per cycle
        fetch_redirect_ready = 1'b0;
        set_src(0, 6'd0, 32'h0);
        step();
        expect_out("sat_hold", 1'b1, 32'h0, 6'd0, 32'd8, 16'd7);
        for (int s = 0; s < NS; s++) set_src(s, 6'd5, 32'h555);
        repeat (17500) @(posedge clk);
        #1;
        expect_out("saturate", 1'b1, 32'h0, 6'd0, 32'd8, 16'hFFFF);
        step();
        check("sat_hold_ffff", 32'(drop_count), 32'hFFFF);

        // asynchronous reset in PENDING
        clr();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.valid", 32'(fetch_redirect_valid), 32'd0);
        check("rst.pc",    fetch_redirect_pc, 32'd0);
        check("rst.id",    32'(fetch_redirect_id), 32'd0);
        check("rst.count", redirect_count, 32'd0);
        check("rst.drops", 32'(drop_count), 32'd0);
        step();
        rst_n = 1'b1;
        set_src(2, 6'd1, 32'h900);
        step();
        expect_out("post_rst", 1'b1, 32'h900, 6'd1, 32'd0, 16'd0);
        clr();
        fetch_redirect_ready = 1'b1;
        step();
        expect_out("post_rst_acc", 1'b0, 32'h0, 6'd0, 32'd1, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
